mlp_seq_ctrl: RTL and testbench

//  AXI-Lite-configured sequencer for the MLP accelerator core. It holds the control, config, status and result registers.
//  It gates the AXI-Stream input feed into the core, one layer at a time, and issues a start pulse per layer.
//  It waits for the core's done, captures the result and reports status. It sits between the PS-side AXI buses and the MLP datapath.

---
 rtl/mlp_seq_ctrl_if.sv | 34 +++
 rtl/mlp_seq_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_mlp_seq_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mlp_seq_ctrl_if.sv
// AXI-Lite bus bundle between the PS and the MLP sequencer register block.
// Master drives address/data/valids, slave returns readies and responses.
interface mlp_seq_ctrl_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/mlp_seq_ctrl.sv
// AXI-Lite configured layer sequencer for the MLP core: gates the stream feed, pulses start, captures the result.
// Optional feature macro: MLP_SEQ_CTRL_IRQ_EN (adds irq_o, CTRL.IRQ_EN and STATUS.done write-1-to-clear).
module mlp_seq_ctrl #(
   parameter int WIDTH                = 16,
   parameter int C_S_AXI_DATA_WIDTH   = 32,
   parameter int C_S_AXI_ADDR_WIDTH   = 4,
   parameter int C_S_AXIS_TDATA_WIDTH = 32
) (
   input  logic                            clk,
   input  logic                            rst_n,
   mlp_seq_ctrl_if.slave                   s_axi,
   input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata_i,
   input  logic                            s_axis_tvalid_i,
   input  logic                            s_axis_tlast_i,
   output logic                            s_axis_tready_o,
   output logic                            core_start_o,
   output logic [3:0]                      core_layer_o,
   output logic [WIDTH-1:0]                core_data_o,
   output logic                            core_valid_o,
   input  logic                            core_ready_i,
   input  logic                            core_done_i,
   input  logic [WIDTH-1:0]                core_res_i
`ifdef MLP_SEQ_CTRL_IRQ_EN
   ,
   output logic                            irq_o
`endif
);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

   localparam int EXT = C_S_AXI_DATA_WIDTH - WIDTH;

   state_t                          state_q;
   logic [15:0]                     wordCnt_q, runWords_q, cfgWords_q;
   logic [3:0]                      layer_q, runLayers_q, cfgLayers_q;
   logic                            done_q, tlastErr_q, cfgErr_q, coreStart_q;
   logic [C_S_AXI_DATA_WIDTH-1:0]   result_q, rdata_q, rdata_d;
   logic                            awready_q, bvalid_q, arready_q, rvalid_q;
   logic [C_S_AXI_ADDR_WIDTH-1:0]   wrAddr, rdAddr;
   logic                            wrEn, wrCtrl, wrCfg, wrStatus, startCmd, softRst, doneClr;
   logic                            inLoad, xfer, lastWord;
   logic                            unusedOk;

   assign wrAddr   = s_axi.awaddr;
   assign rdAddr   = s_axi.araddr;
   assign wrEn     = awready_q;
   assign wrCtrl   = wrEn && (wrAddr[3:2] == 2'd0);
   assign wrCfg    = wrEn && (wrAddr[3:2] == 2'd1);
   assign wrStatus = wrEn && (wrAddr[3:2] == 2'd2);
   assign startCmd = wrCtrl & s_axi.wdata[0];
   assign softRst  = wrCtrl & s_axi.wdata[1];

   assign inLoad   = (state_q == LOAD);
   assign xfer     = inLoad & s_axis_tvalid_i & core_ready_i;
   assign lastWord = (wordCnt_q == runWords_q - 16'd1);

   assign s_axis_tready_o = core_ready_i & inLoad;
   assign core_valid_o    = s_axis_tvalid_i & inLoad;
   assign core_data_o     = s_axis_tdata_i[WIDTH-1:0];
   assign core_start_o    = coreStart_q;
   assign core_layer_o    = layer_q;

   assign s_axi.awready = awready_q;
   assign s_axi.wready  = awready_q;
   assign s_axi.bresp   = 2'b00;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.arready = arready_q;
   assign s_axi.rdata   = rdata_q;
   assign s_axi.rresp   = 2'b00;
   assign s_axi.rvalid  = rvalid_q;

   assign unusedOk = ^{s_axi.wstrb, s_axi.wdata, wrAddr, rdAddr, s_axis_tdata_i, wrStatus};

`ifdef MLP_SEQ_CTRL_IRQ_EN
   logic irqEn_q, irq_q;
   assign doneClr = wrStatus & s_axi.wdata[1];
   assign irq_o   = irq_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irqEn_q <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         if (wrCtrl) irqEn_q <= s_axi.wdata[2];
         irq_q <= done_q & irqEn_q;
      end
   end
`else
   assign doneClr = 1'b0;
`endif

   // Read data is sampled in the arready cycle so a response reflects the registers at acceptance.
   always_comb begin
      rdata_d = '0;
      case (rdAddr[3:2])
         2'd0: begin
`ifdef MLP_SEQ_CTRL_IRQ_EN
            rdata_d[2] = irqEn_q;
`endif
         end
         2'd1: begin
            rdata_d[15:0]  = cfgWords_q;
            rdata_d[19:16] = cfgLayers_q;
         end
         2'd2: begin
            rdata_d[0]    = (state_q != IDLE);
            rdata_d[1]    = done_q;
            rdata_d[2]    = tlastErr_q;
            rdata_d[3]    = cfgErr_q;
            rdata_d[11:8] = layer_q;
         end
         default: rdata_d = result_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         awready_q   <= 1'b0;
         bvalid_q    <= 1'b0;
         arready_q   <= 1'b0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
         cfgWords_q  <= '0;
         cfgLayers_q <= '0;
      end else begin
         awready_q <= s_axi.awvalid & s_axi.wvalid & ~bvalid_q & ~awready_q;
         if (awready_q)         bvalid_q <= 1'b1;
         else if (s_axi.bready) bvalid_q <= 1'b0;
         arready_q <= s_axi.arvalid & ~rvalid_q & ~arready_q;
         if (arready_q) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rdata_d;
         end else if (s_axi.rready) begin
            rvalid_q <= 1'b0;
         end
         if (wrCfg) begin
            cfgWords_q  <= s_axi.wdata[15:0];
            cfgLayers_q <= s_axi.wdata[19:16];
         end
      end
   end

   // Run limits are latched at START so CFG writes during a run only affect the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wordCnt_q   <= '0;
         layer_q     <= '0;
         runWords_q  <= '0;
         runLayers_q <= '0;
         done_q      <= 1'b0;
         tlastErr_q  <= 1'b0;
         cfgErr_q    <= 1'b0;
         result_q    <= '0;
         coreStart_q <= 1'b0;
      end else if (softRst) begin
         state_q     <= IDLE;
         wordCnt_q   <= '0;
         layer_q     <= '0;
         done_q      <= 1'b0;
         tlastErr_q  <= 1'b0;
         cfgErr_q    <= 1'b0;
         result_q    <= '0;
         coreStart_q <= 1'b0;
      end else begin
         coreStart_q <= 1'b0;
         if (doneClr) done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (startCmd) begin
                  if (cfgWords_q != 16'd0 && cfgLayers_q != 4'd0) begin
                     state_q     <= LOAD;
                     coreStart_q <= 1'b1;
                     runWords_q  <= cfgWords_q;
                     runLayers_q <= cfgLayers_q;
                     wordCnt_q   <= '0;
                     layer_q     <= '0;
                     done_q      <= 1'b0;
                     tlastErr_q  <= 1'b0;
                     cfgErr_q    <= 1'b0;
                  end else begin
                     cfgErr_q <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (xfer) begin
                  if (s_axis_tlast_i != lastWord) tlastErr_q <= 1'b1;
                  if (lastWord) begin
                     wordCnt_q <= '0;
                     state_q   <= WAIT;
                  end else begin
                     wordCnt_q <= wordCnt_q + 16'd1;
                  end
               end
            end
            WAIT: begin
               if (core_done_i) begin
                  if (layer_q == runLayers_q - 4'd1) begin
                     result_q <= {{EXT{core_res_i[WIDTH-1]}}, core_res_i};
                     state_q  <= DONE;
                  end else begin
                     layer_q     <= layer_q + 4'd1;
                     coreStart_q <= 1'b1;
                     state_q     <= LOAD;
                  end
               end
            end
            DONE: begin
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mlp_seq_ctrl.sv
// Randomized self-checking bench for mlp_seq_ctrl; expectations come from a job-level model of
// the register file (cfg, sticky status bits, layer, result) rather than from the FSM structure.
module tb_mlp_seq_ctrl;

   logic        clk;
   logic        rst_n;
   logic [31:0] tdata;
   logic        tvalid, tlast, sAxisTready;
   logic        coreStart, coreValid, coreReady, coreDone;
   logic [3:0]  coreLayer;
   logic [15:0] coreData, coreRes;
`ifdef MLP_SEQ_CTRL_IRQ_EN
   logic        irq;
`endif

   int vectors     = 0;
   int miscompares = 0;
   int startCount  = 0;
   int wordsSeen   = 0;
   int startsBefore, wordsBefore;

   // Job-level model of the software-visible status
   logic       mDone, mTlastErr, mCfgErr;
   logic [3:0] mLayer;

   mlp_seq_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

   mlp_seq_ctrl dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .s_axi           (bus),
      .s_axis_tdata_i  (tdata),
      .s_axis_tvalid_i (tvalid),
      .s_axis_tlast_i  (tlast),
      .s_axis_tready_o (sAxisTready),
      .core_start_o    (coreStart),
      .core_layer_o    (coreLayer),
      .core_data_o     (coreData),
      .core_valid_o    (coreValid),
      .core_ready_i    (coreReady),
      .core_done_i     (coreDone),
      .core_res_i      (coreRes)
`ifdef MLP_SEQ_CTRL_IRQ_EN
      ,
      .irq_o           (irq)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count start pulses and accepted stream words as the core would see them
   always @(posedge clk) begin
      if (coreStart) startCount++;
      if (coreValid && sAxisTready) wordsSeen++;
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] simulation watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] expStatus(input logic busy);
      return {20'h0, mLayer, 4'h0, mCfgErr, mTlastErr, mDone, busy};
   endfunction

   task automatic clearModel();
      mDone = 1'b0; mTlastErr = 1'b0; mCfgErr = 1'b0; mLayer = 4'h0;
   endtask

   task automatic axiWrite(input logic [3:0] addr, input logic [31:0] data, input int awLead);
      int n;
      bus.awaddr = addr; bus.wdata = data; bus.wstrb = 4'hF; bus.awvalid = 1'b1;
      for (int i = 0; i < awLead; i++) begin
         @(negedge clk);
         checkOutput("aw_only_awready", 32'(bus.awready), 32'h0);
         checkOutput("aw_only_bvalid", 32'(bus.bvalid), 32'h0);
      end
      bus.wvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.awready && n < 20);
      if (!bus.awready) checkOutput("awready_timeout", 32'h0, 32'h1);
      @(negedge clk);
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      checkOutput("bvalid", 32'(bus.bvalid), 32'h1);
   endtask

   task automatic readCheck(input logic [3:0] addr, input logic [31:0] expected, input string tag);
      int n;
      bus.araddr = addr; bus.arvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.arready && n < 20);
      if (!bus.arready) checkOutput("arready_timeout", 32'h0, 32'h1);
      @(negedge clk);
      bus.arvalid = 1'b0;
      checkOutput("rvalid", 32'(bus.rvalid), 32'h1);
      checkOutput(tag, bus.rdata, expected);
   endtask

   task automatic feedWord(input logic [31:0] data, input logic tl, input int L);
      int n; bit acc;
      n = 0; acc = 0;
      while (!acc && n < 64) begin
         @(negedge clk);
         tdata = data; tlast = tl;
         tvalid    = ($urandom_range(0, 3) != 0);
         coreReady = ($urandom_range(0, 3) != 0);
         #1;
         checkOutput("tready_load", 32'(sAxisTready), 32'(coreReady));
         if (tvalid && coreReady) begin
            acc = 1;
            checkOutput("core_valid", 32'(coreValid), 32'h1);
            checkOutput("core_data", 32'(coreData), 32'(data[15:0]));
            checkOutput("core_layer", 32'(coreLayer), 32'(L));
         end
         n++;
      end
      if (!acc) checkOutput("word_timeout", 32'h0, 32'h1);
   endtask

   task automatic pulseDone(input logic [15:0] res);
      @(negedge clk);
      tvalid = 1'b0; coreDone = 1'b1; coreRes = res;
      @(negedge clk);
      coreDone = 1'b0;
   endtask

   // One full job: program CFG, START, stream every layer, answer each with core_done, then audit
   task automatic applyStimulus(input int words, input int layers, input int errPos, input bit randErr,
                                input bit forceLast, input logic [15:0] lastRes, input bit spurious,
                                input int awLead);
      bit expErr;
      logic [15:0] res;
      logic tl;
      expErr = 0; res = '0;
      axiWrite(4'h4, {12'h0, 4'(layers), 16'(words)}, awLead);
      startsBefore = startCount; wordsBefore = wordsSeen;
      axiWrite(4'h0, 32'h1, 0);
      clearModel();
      for (int L = 0; L < layers; L++) begin
         if (spurious && L == 0) pulseDone(16'h1234);
         for (int w = 0; w < words; w++) begin
            tl = (w == words - 1);
            if (L == 0 && w == errPos) tl = 1'b1;
            if (randErr && $urandom_range(0, 7) == 0) tl = ~tl;
            if (tl != (w == words - 1)) expErr = 1;
            feedWord($urandom(), tl, L);
         end
         @(negedge clk);
         tvalid = 1'b0; coreReady = 1'b1;
         #1;
         checkOutput("tready_wait", 32'(sAxisTready), 32'h0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         res = (forceLast && L == layers - 1) ? lastRes : 16'($urandom());
         pulseDone(res);
         mLayer = 4'(L);
      end
      @(negedge clk);
      mDone = 1'b1; mTlastErr = expErr;
      checkOutput("start_pulses", 32'(startCount - startsBefore), 32'(layers));
      checkOutput("words_taken", 32'(wordsSeen - wordsBefore), 32'(words * layers));
      readCheck(4'h8, expStatus(1'b0), "status");
      readCheck(4'hC, {{16{res[15]}}, res}, "result");
   endtask

   initial begin
      rst_n = 1'b0;
      tdata = '0; tvalid = 1'b1; tlast = 1'b0; coreReady = 1'b1; coreDone = 1'b0; coreRes = '0;
      bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
      bus.bready = 1'b1; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
      clearModel();

      repeat (3) @(negedge clk);
      #1;
      checkOutput("rst_tready", 32'(sAxisTready), 32'h0);
      checkOutput("rst_core_valid", 32'(coreValid), 32'h0);
      checkOutput("rst_core_start", 32'(coreStart), 32'h0);
      checkOutput("rst_core_layer", 32'(coreLayer), 32'h0);
      checkOutput("rst_awready", 32'(bus.awready), 32'h0);
      checkOutput("rst_bvalid", 32'(bus.bvalid), 32'h0);
      checkOutput("rst_rvalid", 32'(bus.rvalid), 32'h0);
      checkOutput("rst_rdata", bus.rdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1; tvalid = 1'b0;
      readCheck(4'h0, 32'h0, "rst_ctrl");
      readCheck(4'h4, 32'h0, "rst_cfg");
      readCheck(4'h8, 32'h0, "rst_status");
      readCheck(4'hC, 32'h0, "rst_result");

      $display("[TB] directed jobs");
      applyStimulus(3, 2, -1, 1'b0, 1'b0, 16'h0, 1'b0, 0);
      readCheck(4'h4, 32'h0002_0003, "cfg_readback");
      applyStimulus(3, 1, -1, 1'b0, 1'b1, 16'hFFF0, 1'b0, 3);
      applyStimulus(3, 1, 1, 1'b0, 1'b1, 16'h00A5, 1'b1, 0);

      $display("[TB] config errors");
      startsBefore = startCount;
      axiWrite(4'h4, 32'h0002_0000, 0);
      axiWrite(4'h0, 32'h1, 0);
      repeat (3) @(negedge clk);
      mCfgErr = 1'b1;
      checkOutput("cfgerr_words_no_start", 32'(startCount - startsBefore), 32'h0);
      readCheck(4'h8, expStatus(1'b0), "status_cfgerr_words");
      axiWrite(4'h4, 32'h0000_0003, 0);
      axiWrite(4'h0, 32'h1, 0);
      repeat (3) @(negedge clk);
      checkOutput("cfgerr_layers_no_start", 32'(startCount - startsBefore), 32'h0);
      readCheck(4'h8, expStatus(1'b0), "status_cfgerr_layers");

      $display("[TB] stall, restart and soft reset");
      axiWrite(4'h4, 32'h0001_0004, 0);
      startsBefore = startCount; wordsBefore = wordsSeen;
      axiWrite(4'h0, 32'h1, 0);
      clearModel();
      @(negedge clk);
      tvalid = 1'b1; coreReady = 1'b0; tdata = $urandom(); tlast = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         checkOutput("stall_tready", 32'(sAxisTready), 32'h0);
         @(negedge clk);
      end
      checkOutput("stall_words", 32'(wordsSeen - wordsBefore), 32'h0);
      feedWord($urandom(), 1'b0, 0);
      @(negedge clk);
      tvalid = 1'b0;
      axiWrite(4'h0, 32'h1, 0);
      repeat (2) @(negedge clk);
      checkOutput("restart_ignored", 32'(startCount - startsBefore), 32'h1);
      readCheck(4'h8, expStatus(1'b1), "status_busy");
      coreReady = 1'b1;
      #1;
      checkOutput("tready_before_srst", 32'(sAxisTready), 32'h1);
      axiWrite(4'h0, 32'h2, 0);
      #1;
      checkOutput("tready_after_srst", 32'(sAxisTready), 32'h0);
      readCheck(4'h8, expStatus(1'b0), "status_after_srst");
      readCheck(4'h4, 32'h0001_0004, "cfg_kept");
      readCheck(4'hC, 32'h0, "result_cleared");
      applyStimulus(4, 1, -1, 1'b0, 1'b0, 16'h0, 1'b0, 0);

      $display("[TB] async reset mid-run");
      axiWrite(4'h4, 32'h0002_0003, 0);
      axiWrite(4'h0, 32'h1, 0);
      feedWord($urandom(), 1'b0, 0);
      feedWord($urandom(), 1'b0, 0);
      @(negedge clk);
      rst_n = 1'b0; tvalid = 1'b1; coreReady = 1'b1;
      #1;
      checkOutput("arst_tready", 32'(sAxisTready), 32'h0);
      checkOutput("arst_core_valid", 32'(coreValid), 32'h0);
      checkOutput("arst_core_layer", 32'(coreLayer), 32'h0);
      @(negedge clk);
      rst_n = 1'b1; tvalid = 1'b0;
      clearModel();
      readCheck(4'h8, expStatus(1'b0), "status_after_arst");
      readCheck(4'h4, 32'h0, "cfg_after_arst");

      $display("[TB] random jobs");
      for (int j = 0; j < 10; j++) begin
         applyStimulus($urandom_range(1, 5), $urandom_range(1, 4), -1, 1'b1, 1'b0, 16'h0,
                       1'($urandom_range(0, 1)), $urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
